// File: rtl/riscv_core_pkg.sv
// Shared core package: divider op encoding, FSM states and op helpers.
// Imported by the divider and its output select.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic div_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/riscv_core_mux2x1.sv
// Generic 2:1 select, used for the divider quotient/remainder pick.
module riscv_core_mux2x1 #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/riscv_core_divider.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Fixed XLEN-cycle iteration; divide-by-zero and overflow finish in one edge.
module riscv_core_divider
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);

    localparam int CW = $clog2(XLEN) + 1;

    div_state_e      state_q, state_d;
    div_op_e         op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, dvs_q;
    logic [XLEN:0]   rem_q;
    logic            qneg_q, rneg_q;

    div_op_e         op_in;
    logic            in_signed, div_zero, overflow, special;
    logic            take_start, load_res, last;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   rem_sh, diff, rem_it;
    logic            ge;
    logic [XLEN-1:0] quo_it, q_fin, r_fin;
    logic [XLEN-1:0] mux_q, mux_r, res_d;
    logic            mux_sel;

    assign op_in     = div_op_e'(i_div_op);
    assign in_signed = div_is_signed(op_in);
    assign div_zero  = (i_div_rs2 == '0);
    assign overflow  = in_signed && &i_div_rs2
                    && (i_div_rs1 == {1'b1, {(XLEN-1){1'b0}}});
    assign special   = div_zero || overflow;

    assign take_start = i_div_start && !i_div_flush
                     && (state_q != DIV_CALC);

    assign abs1 = (in_signed && i_div_rs1[XLEN-1]) ? -i_div_rs1 : i_div_rs1;
    assign abs2 = (in_signed && i_div_rs2[XLEN-1]) ? -i_div_rs2 : i_div_rs2;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = !diff[XLEN];
    assign rem_it = ge ? diff : rem_sh;
    assign quo_it = {quo_q[XLEN-2:0], ge};
    assign last   = (cnt_q == CW'(XLEN - 1));

    assign q_fin = qneg_q ? -quo_it : quo_it;
    assign r_fin = rneg_q ? -rem_it[XLEN-1:0] : rem_it[XLEN-1:0];

    // CALC finishes from the iteration; IDLE/DONE only load on special cases.
    always_comb begin
        mux_q   = q_fin;
        mux_r   = r_fin;
        mux_sel = div_is_rem(op_q);
        if (state_q != DIV_CALC) begin
            mux_q   = div_zero ? '1 : i_div_rs1;
            mux_r   = div_zero ? i_div_rs1 : '0;
            mux_sel = div_is_rem(op_in);
        end
    end

    riscv_core_mux2x1 #(
        .WIDTH (XLEN)
    ) u_res_mux (
        .i_sel (mux_sel),
        .i_d0  (mux_q),
        .i_d1  (mux_r),
        .o_y   (res_d)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_res    = 1'b0;
        o_div_busy  = (state_q == DIV_CALC);
        o_div_valid = (state_q == DIV_DONE);
        unique case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (take_start) begin
                    state_d  = special ? DIV_DONE : DIV_CALC;
                    load_res = special;
                end
            end
            DIV_CALC: begin
                if (i_div_flush) begin
                    state_d = DIV_IDLE;
                end else if (last) begin
                    state_d  = DIV_DONE;
                    load_res = 1'b1;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            op_q         <= DIV_OP_DIV;
            cnt_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            o_div_result <= '0;
        end else begin
            if (load_res) begin
                o_div_result <= res_d;
            end
            if (take_start) begin
                op_q   <= op_in;
                cnt_q  <= '0;
                quo_q  <= abs1;
                dvs_q  <= abs2;
                rem_q  <= '0;
                qneg_q <= in_signed && (i_div_rs1[XLEN-1] ^ i_div_rs2[XLEN-1]);
                rneg_q <= in_signed && i_div_rs1[XLEN-1];
            end else if (state_q == DIV_CALC) begin
                cnt_q <= cnt_q + CW'(1);
                quo_q <= quo_it;
                rem_q <= rem_it;
            end
        end
    end

endmodule
